// File: rtl/cdcfifo_wr_arbiter.sv
// Round-robin arbiter sharing one cdcfifo write port among NUM_REQ
// valid/ready requesters, with bounded bursts and a bubble between grants.
module cdcfifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wrclk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic                          writeValid,
    output logic [FIFO_WIDTH-1:0]         writeData,
    input  logic                          writeReady,
    output logic                          grantValid,
    output logic [2:0]                    grantId,
    output logic [15:0]                   xferCount
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_grantId;
    logic [2:0]            r_lastGrant;
    logic [7:0]            r_beatCnt;
    logic [15:0]           r_xferCount;
    logic [2:0]            w_pick;
    logic                  w_found;
    logic                  w_selValid;
    logic [FIFO_WIDTH-1:0] w_selData;
    logic                  w_xfer;
    logic                  w_release;

    // Lowest index above lastGrant wins; otherwise wrap to the lowest index.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (reqValid[i] && (3'(i) <= r_lastGrant)) begin
                w_found = 1'b1;
                w_pick  = 3'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (reqValid[i] && (3'(i) > r_lastGrant)) begin
                w_found = 1'b1;
                w_pick  = 3'(i);
            end
        end
    end

    always_comb begin
        w_selValid = 1'b0;
        w_selData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grantId == 3'(i)) begin
                w_selValid = reqValid[i];
                w_selData  = reqData[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        writeValid = 1'b0;
        writeData  = '0;
        reqReady   = '0;
        w_xfer     = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next = GRANT;
                end
            end
            GRANT: begin
                writeValid = w_selValid;
                writeData  = w_selData;
                for (int i = 0; i < NUM_REQ; i++) begin
                    reqReady[i] = (r_grantId == 3'(i)) && writeReady;
                end
                w_xfer    = w_selValid && writeReady;
                w_release = !w_selValid ||
                            (w_xfer && (r_beatCnt == 8'(MAX_BURST - 1)));
                if (w_release) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wrclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grantId   <= '0;
            r_lastGrant <= 3'(NUM_REQ - 1);
            r_beatCnt   <= '0;
            r_xferCount <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_found) begin
                r_grantId <= w_pick;
                r_beatCnt <= '0;
            end
            if (w_xfer) begin
                r_beatCnt   <= r_beatCnt + 8'd1;
                r_xferCount <= r_xferCount + 16'd1;
            end
            // grantId reads as zero whenever no grant is held
            if (w_release) begin
                r_lastGrant <= r_grantId;
                r_grantId   <= '0;
            end
        end
    end

    assign grantValid = (r_state == GRANT);
    assign grantId    = r_grantId;
    assign xferCount  = r_xferCount;

endmodule

// File: doc/cdcfifo_wr_arbiter.md
Name: cdcfifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of one cdcfifo instance between NUM_REQ write requesters in the write clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst and steers its data and valid to the FIFO. It returns the FIFO's writeReady only to the granted requester. The arbiter sits directly in front of the cdcfifo write side and runs entirely on wrclk.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FIFO_WIDTH, 8, data width, equal to the attached cdcfifo FIFO_WIDTH
MAX_BURST, 4, maximum accepted beats per grant (1..255)

Ports:
wrclk  input  1  write-domain clock; all logic on posedge
rst  input  1  synchronous active-high reset
reqValid  input  NUM_REQ  per-requester valid
reqData  input  NUM_REQ*FIFO_WIDTH  per-requester data; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
reqReady  output  NUM_REQ  per-requester ready (one-hot or zero)
writeValid  output  1  to cdcfifo writeValid
writeData  output  FIFO_WIDTH  to cdcfifo writeData
writeReady  input  1  from cdcfifo writeReady
grantValid  output  1  high while a grant is held
grantId  output  3  index of the granted requester; 0 when grantValid=0
xferCount  output  16  total accepted beats, wraps at 0xFFFF->0

Behaviour:
- Transfer definition: a beat transfers on a posedge where writeValid && writeReady. Requesters must hold valid and data stable until ready. The arbiter does not check this rule.
- Reset (rst=1 at posedge):
  - state=IDLE, grantValid=0, grantId=0, beatCnt=0, xferCount=0.
  - lastGrant=NUM_REQ-1, so requester 0 has first priority.
  - Combinational outputs follow from state: reqReady=0, writeValid=0, writeData=0.
  - Reset mid-burst drops the grant at once; the beat in that cycle is not counted.
- FSM state IDLE:
  - writeValid=0, reqReady=0.
  - If any reqValid is high, the posedge selects the first set bit searching lastGrant+1, lastGrant+2, ... modulo NUM_REQ. It registers grantId, sets beatCnt=0 and moves to GRANT.
  - Arbitration latency is 1 cycle: the earliest transfer is at the second posedge after reqValid rises.
- FSM state GRANT (g=grantId):
  - writeValid=reqValid[g], writeData=reqData slice g.
  - reqReady[g]=writeReady; every other reqReady bit is 0. These are combinational paths.
  - On a transfer: beatCnt++ and xferCount++.
  - Release to IDLE with lastGrant=g when either:
    (a) a transfer occurs with beatCnt==MAX_BURST-1, or
    (b) reqValid[g]==0 at a posedge (requester idle).
  - Case (b) does not count a beat.
  - A full FIFO (writeReady=0) with reqValid[g]=1 keeps the grant indefinitely. There is no timeout; the beat is held, not dropped.
- Release always passes through IDLE. This gives a 1-cycle bubble between grants, so the FIFO sees at most MAX_BURST beats per MAX_BURST+1 cycles from one requester under contention.
- A single active requester is re-granted after each bubble, so there is no starvation of a lone requester.
- Fairness: with all requesters active, the grant order is 0,1,...,NUM_REQ-1,0,... Each requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles of other grants, plus any FIFO-full stall.
- Non-granted requesters asserting valid see reqReady=0 and must hold their beat.
- grantValid=1 exactly in GRANT. grantId is registered and stable for the whole grant.
- Widths:
  - beatCnt is 8 bits.
  - Index arithmetic is modulo NUM_REQ. Bit positions of reqValid at or above NUM_REQ do not exist.
  - grantId is zero-extended to 3 bits.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all reqValid=0 -> reqReady=0, writeValid=0, grantValid=0, xferCount=0; the FSM stays in IDLE.
- Single requester burst: reqValid=4'b0100, data 0xA0..0xA5, writeReady=1 -> grantId=2 one cycle later. Beats 0xA0-0xA3 are accepted, then a 1-cycle bubble, then a re-grant to 2 delivering 0xA4, 0xA5. xferCount=6.
- Full contention round robin: reqValid=4'b1111 held, writeReady=1, MAX_BURST=4 -> grantId sequence 0,1,2,3,0 with 4 beats each and 1 idle cycle between grants. xferCount=16 after the first 20 GRANT/IDLE cycles.
- FIFO backpressure: requester 1 granted, writeReady=0 for 10 cycles, then 1 -> reqReady[1]=0 and grant held throughout. The pending beat 0x5C transfers on the first ready cycle; no beat is lost or duplicated.
- Early release and skip: reqValid[0] drops after 2 beats while reqValid=4'b1010 -> grant 0 releases with beatCnt=2. The next grant is 1, then 3, skipping idle requester 2.
- Reset mid-burst and counter wrap: assert rst during the 3rd beat of a grant -> grantValid=0 next cycle, xferCount=0, the next grant goes to requester 0. Separately, force 65536 transfers -> xferCount returns to 0x0000.
